// File: rtl/fifo_tx_pkg.sv
// Shared types and default sizing for the FIFO serial transmitter.
package fifo_tx_pkg;

  localparam int unsigned DEPTH_BITS_DEF = 4;
  localparam int unsigned WIDTH_DEF      = 6;
  localparam int unsigned DIV_BITS_DEF   = 8;
  localparam bit          PARITY_EN_DEF  = 1'b1;

  // Bit periods per frame: start + data + optional parity + stop.
  localparam int unsigned FRAME_BITS = 2 + WIDTH_DEF + (PARITY_EN_DEF ? 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read-port bundle between the FIFO (slave) and the serial transmitter (master).
interface fifo_serial_tx_if
  import fifo_tx_pkg::*;
#(
  parameter int unsigned DEPTH_BITS = DEPTH_BITS_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF
);

  logic                  fifo_empty_n;
  logic [WIDTH-1:0]      fifo_data;
  logic [DEPTH_BITS-1:0] fifo_peek;
  logic                  fifo_pop;

  modport master (
    input  fifo_empty_n,
    input  fifo_data,
    output fifo_peek,
    output fifo_pop
  );

  modport slave (
    output fifo_empty_n,
    output fifo_data,
    input  fifo_peek,
    input  fifo_pop
  );

endinterface

// File: rtl/bit_timer.sv
// Bit-period down-counter; strobes bit_end_c on the last clock of every bit period.
module bit_timer
  import fifo_tx_pkg::*;
#(
  parameter int unsigned DIV_BITS = DIV_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DIV_BITS-1:0] divider,
  output logic                bit_end_c
);

  logic [DIV_BITS-1:0] period_q;
  logic [DIV_BITS-1:0] cnt_q;

  // Divider is captured only at load, so mid-frame changes wait for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      period_q <= divider;
      cnt_q    <= divider;
    end else if (cnt_q == '0) begin
      cnt_q <= period_q;
    end else begin
      cnt_q <= cnt_q - DIV_BITS'(1);
    end
  end

  assign bit_end_c = (cnt_q == '0);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from the FIFO head and sends each as start / data LSB-first / even parity / stop.
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int unsigned DEPTH_BITS = DEPTH_BITS_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned DIV_BITS   = DIV_BITS_DEF,
  parameter bit          PARITY_EN  = PARITY_EN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  fifo_serial_tx_if.master    rd,
  input  logic [DIV_BITS-1:0] divider,
  input  logic                enable,
  output logic                tx,
  output logic                busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  tx_state_e        state_q;
  tx_state_e        state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;
  logic             par_q;
  logic             tx_d;
  logic             busy_d;
  logic             bit_end_c;
  logic             launch_c;
  logic             pop_c;
  logic             last_data_c;

  // A new frame may start from IDLE or from the final STOP clock; never under reset.
  assign launch_c    = enable && rd.fifo_empty_n;
  assign pop_c       = !reset && launch_c &&
                       ((state_q == IDLE) || ((state_q == STOP) && bit_end_c));
  assign last_data_c = (bit_cnt_q == CNT_W'(WIDTH - 1));

  assign rd.fifo_pop  = pop_c;
  assign rd.fifo_peek = DEPTH_BITS'(0);

  bit_timer #(
    .DIV_BITS (DIV_BITS)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (pop_c),
    .divider   (divider),
    .bit_end_c (bit_end_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop_c) state_d = START;
      START:   if (bit_end_c) state_d = DATA;
      DATA:    if (bit_end_c && last_data_c) state_d = PARITY_EN ? PARITY : STOP;
      PARITY:  if (bit_end_c) state_d = STOP;
      STOP:    if (bit_end_c) state_d = pop_c ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx/busy are computed from the next state so the registered line changes on the pop edge.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = 1'b1;
    busy_d    = (state_d != IDLE);
    if (pop_c) begin
      shreg_d   = rd.fifo_data;
      bit_cnt_d = '0;
    end else if ((state_q == DATA) && bit_end_c) begin
      shreg_d   = shreg_q >> 1;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx        <= tx_d;
      busy      <= busy_d;
      if (pop_c) begin
        par_q <= ^rd.fifo_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Scoreboard bench: stimulus queues hand-computed frames, a monitor checks tx/busy every clock.
module tb_fifo_serial_tx;
  import fifo_tx_pkg::*;

  typedef struct {
    logic [FRAME_BITS-1:0] bits;    // bits[0] is transmitted first
    int unsigned           period;  // clocks per bit
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] divider = 8'd0;
  logic       tx;
  logic       busy;

  fifo_serial_tx_if #(.DEPTH_BITS(4), .WIDTH(6)) rd_if ();

  fifo_serial_tx #(
    .DEPTH_BITS (4),
    .WIDTH      (6),
    .DIV_BITS   (8),
    .PARITY_EN  (1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd_if),
    .divider (divider),
    .enable  (enable),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  logic [5:0] fifo_q[$];
  exp_t       exp_q[$];
  int         exp_rd = 0;
  int         pops_seen = 0;
  int         pops_done = 0;
  int         frames_done = 0;
  int         timeouts = 0;
  int         checks = 0;
  int         failures = 0;
  bit         active = 1'b0;
  bit         done = 1'b0;

  function automatic void drive_fifo();
    rd_if.fifo_empty_n = (fifo_q.size() != 0);
    rd_if.fifo_data    = (fifo_q.size() != 0) ? fifo_q[0] : 6'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; apply FIFO pops seen by the monitor after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    while (pops_done < pops_seen) begin
      if (fifo_q.size() != 0) fifo_q.pop_front();
      pops_done++;
    end
    drive_fifo();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [5:0] word, input logic [FRAME_BITS-1:0] frame,
                      input int unsigned period);
    fifo_q.push_back(word);
    exp_q.push_back('{frame, period});
    drive_fifo();
  endtask

  // Wait until at most 'left' frames remain unlaunched and no frame is on the line.
  task automatic wait_idle(input int left, input int budget);
    int n = 0;
    while (((exp_q.size() - exp_rd) > left || active) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) timeouts++;
  endtask

  initial begin : stimulus
    drive_fifo();
    ticks(3);
    reset = 1'b0;
    tick();

    // divider 0, single word 2D
    enable = 1'b1;
    push(6'h2D, 9'b101011010, 1);
    wait_idle(0, 100);
    ticks(3);

    // divider 3, word 01: 4 clocks per bit, 36 busy clocks
    divider = 8'd3;
    push(6'h01, 9'b110000010, 4);
    wait_idle(0, 200);
    ticks(3);

    // back to back 3F then 00
    divider = 8'd0;
    push(6'h3F, 9'b101111110, 1);
    push(6'h00, 9'b100000000, 1);
    wait_idle(0, 100);

    // empty FIFO, then data queued with enable low
    ticks(50);
    enable = 1'b0;
    push(6'h33, 9'b101100110, 1);
    ticks(50);
    enable = 1'b1;
    wait_idle(0, 100);
    ticks(2);

    // enable drops mid-frame: first frame completes, second waits
    divider = 8'd1;
    push(6'h07, 9'b110001110, 2);
    push(6'h38, 9'b111110000, 2);
    ticks(4);
    enable = 1'b0;
    wait_idle(1, 100);
    ticks(20);
    enable = 1'b1;
    wait_idle(0, 100);
    ticks(2);

    // divider 0 -> 7 during DATA: current frame unaffected, next frame 8-clock bits
    divider = 8'd0;
    push(6'h15, 9'b110101010, 1);
    push(6'h2A, 9'b111010100, 8);
    ticks(3);
    divider = 8'd7;
    wait_idle(0, 300);
    ticks(2);

    // one-clock reset during DATA abandons 0C; 21 follows normally
    divider = 8'd0;
    push(6'h0C, 9'b100011000, 1);
    push(6'h21, 9'b101000010, 1);
    ticks(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle(0, 100);
    ticks(5);

    done = 1'b1;
    ticks(3);
  end

  initial begin : monitor
    exp_t cur;
    int   bit_idx;
    int   clk_idx;
    bit   last;
    bit   rst_prev;
    cur      = '{'0, 1};
    bit_idx  = 0;
    clk_idx  = 0;
    rst_prev = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (done) begin
        chk("no_timeout", 32'(timeouts), 32'd0);
        chk("all_frames_launched", 32'(exp_rd), 32'(exp_q.size()));
        chk("frames_completed", 32'(frames_done), 32'd10);
        chk("fifo_drained", 32'(fifo_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      if (rst_prev) active = 1'b0;
      if (active) begin
        last = (bit_idx == int'(FRAME_BITS) - 1) && (clk_idx == int'(cur.period) - 1);
        chk("tx_bit", 32'(tx), 32'(cur.bits[bit_idx]));
        chk("busy_frame", 32'(busy), 32'd1);
        if (rd_if.fifo_pop) chk("pop_only_at_stop_end", 32'(last), 32'd1);
        if (clk_idx == int'(cur.period) - 1) begin
          clk_idx = 0;
          bit_idx++;
        end else begin
          clk_idx++;
        end
        if (last) begin
          active = 1'b0;
          frames_done++;
        end
      end else begin
        chk("tx_idle", 32'(tx), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("peek_zero", 32'(rd_if.fifo_peek), 32'd0);
      end
      if (reset) chk("pop_in_reset", 32'(rd_if.fifo_pop), 32'd0);
      if (rd_if.fifo_pop === 1'b1) begin
        chk("pop_launch_cond", 32'(enable && rd_if.fifo_empty_n), 32'd1);
        if (exp_rd < exp_q.size()) begin
          cur     = exp_q[exp_rd];
          exp_rd++;
          active  = 1'b1;
          bit_idx = 0;
          clk_idx = 0;
        end else begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop: got pop with %0d frames queued, expected none at %0t",
                   exp_q.size() - exp_rd, $time);
        end
        pops_seen++;
      end
      rst_prev = reset;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
